regfile_access_scheduler: RTL

- Sequences and arbitrates all accesses to the 32x32 MIPS register file.
- The register file acts on a rising edge of its enable strobe, and a write needs enable high together with reg_write.
- This block turns per-requester valid/ready transactions from two requesters into a clean, clk-synchronous strobe sequence:
  - the core datapath;
  - the Basys3 debug port (switch/UART register peek and poke).
- It sits between the core control unit, the debug front-end and the register file.

---
 rtl/mips_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 29 ++
 rtl/regfile_access_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the register-file access scheduler.
// Optional build macro used by the scheduler: REGSCHED_ZERO_GUARD_EN.
package mips_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // Requester ids double as bit positions in the request/grant vectors.
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, last-grant pointer advanced on update.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    import mips_pkg::*;

    logic last_reg;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_reg == REQ_CORE) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= REQ_DBG;
        end else if (update && (grant != 2'b00)) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/regfile_access_scheduler.sv
// Serialises core and debug register-file accesses into an IDLE/SETUP/STROBE/CAPTURE strobe sequence.
// Build option: REGSCHED_ZERO_GUARD_EN blocks writes to register index 0.
module regfile_access_scheduler #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_we,
    input  logic [ADDR_W-1:0] core_req_ra1,
    input  logic [ADDR_W-1:0] core_req_ra2,
    input  logic [ADDR_W-1:0] core_req_wa,
    input  logic [DATA_W-1:0] core_req_wdata,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_we,
    input  logic [ADDR_W-1:0] dbg_req_ra1,
    input  logic [ADDR_W-1:0] dbg_req_ra2,
    input  logic [ADDR_W-1:0] dbg_req_wa,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    output logic              core_rsp_valid,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata1,
    output logic [DATA_W-1:0] rsp_rdata2,
    output logic              rf_en,
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              busy
);
    import mips_pkg::*;

    localparam int NREQ = 2;

    state_t            state_reg, state_next;
    logic [NREQ-1:0]   req_valid, req_ready, grant, rsp_valid_reg;
    logic              accept, sel_we, we_eff, we_reg, owner_reg;
    logic [ADDR_W-1:0] sel_ra1, sel_ra2, sel_wa, ra1_reg, ra2_reg, wa_reg;
    logic [DATA_W-1:0] sel_wdata, wdata_reg, rdata1_reg, rdata2_reg;

    assign req_valid = {dbg_req_valid, core_req_valid};

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .update (accept),
        .grant  (grant)
    );

    // Ready is only offered from IDLE and never while reset is held.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = !rst && (state_reg == IDLE) && grant[gi];
    end

    assign accept         = |req_ready;
    assign core_req_ready = req_ready[REQ_CORE];
    assign dbg_req_ready  = req_ready[REQ_DBG];

    always_comb begin
        sel_we    = core_req_we;
        sel_ra1   = core_req_ra1;
        sel_ra2   = core_req_ra2;
        sel_wa    = core_req_wa;
        sel_wdata = core_req_wdata;
        if (grant[REQ_DBG]) begin
            sel_we    = dbg_req_we;
            sel_ra1   = dbg_req_ra1;
            sel_ra2   = dbg_req_ra2;
            sel_wa    = dbg_req_wa;
            sel_wdata = dbg_req_wdata;
        end
    end

`ifdef REGSCHED_ZERO_GUARD_EN
    // The handshake still runs normally; only the write enable is suppressed.
    assign we_eff = sel_we && (sel_wa != '0);
`else
    assign we_eff = sel_we;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            owner_reg     <= REQ_CORE;
            ra1_reg       <= '0;
            ra2_reg       <= '0;
            wa_reg        <= '0;
            wdata_reg     <= '0;
            rdata1_reg    <= '0;
            rdata2_reg    <= '0;
            rsp_valid_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg    <= we_eff;
                owner_reg <= grant[REQ_DBG];
                ra1_reg   <= sel_ra1;
                ra2_reg   <= sel_ra2;
                wa_reg    <= sel_wa;
                wdata_reg <= sel_wdata;
            end
            if (state_reg == CAPTURE) begin
                rdata1_reg <= rf_read_data1;
                rdata2_reg <= rf_read_data2;
            end
            rsp_valid_reg <= (state_reg == CAPTURE) ? (NREQ'(1) << owner_reg) : '0;
        end
    end

    assign rf_en          = (state_reg == STROBE);
    assign rf_reg_write   = we_reg && ((state_reg == SETUP) || (state_reg == STROBE));
    assign rf_read_reg1   = ra1_reg;
    assign rf_read_reg2   = ra2_reg;
    assign rf_write_reg   = wa_reg;
    assign rf_write_data  = wdata_reg;
    assign rsp_rdata1     = rdata1_reg;
    assign rsp_rdata2     = rdata2_reg;
    assign core_rsp_valid = rsp_valid_reg[REQ_CORE];
    assign dbg_rsp_valid  = rsp_valid_reg[REQ_DBG];
    assign busy           = (state_reg != IDLE);

endmodule
